// File: rtl/ajuste_relogio.sv
// ajuste_relogio: time-setting controller for a HH:MM clock.
// Buttons step through hour edit, minute edit and a load phase that holds
// LD_time high until the next one-second tick. An idle timeout abandons
// the edit, and a blink timer drives the display blink of the field being edited.
module ajuste_relogio #(
  parameter int BLINK_CICLOS = 5,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1s,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       editando,
  output logic       pisca_h,
  output logic       pisca_m
);

  // Counter widths: each counter only needs to reach its parameter minus one.
  localparam int BW = (BLINK_CICLOS > 1) ? $clog2(BLINK_CICLOS) : 1;
  localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CICLOS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    edit_h_q, edit_h_d;
  logic [5:0]    edit_m_q, edit_m_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          mode_prev_q, mode_prev_d;
  logic          inc_prev_q, inc_prev_d;

  // Edge detection on the (already synchronous) button levels.
  logic press_mode;
  logic press_inc;
  logic any_press;
  assign press_mode = btn_mode & ~mode_prev_q;
  assign press_inc  = btn_inc & ~inc_prev_q;
  assign any_press  = press_mode | press_inc;

  // Current time converted to binary for the edit registers. The arithmetic
  // is done at the destination width; valid times always fit.
  logic [4:0] cap_h;
  logic [5:0] cap_m;
  assign cap_h = 5'(cur_H1) * 5'd10 + 5'(cur_H0);
  assign cap_m = 6'(cur_M1) * 6'd10 + 6'(cur_M0);

  logic editing_q;
  logic timeout_hit;
  logic entering_edit;
  assign editing_q   = (state_q == ST_SET_H) || (state_q == ST_SET_M);
  // A press in the same cycle as the last tick wins over the timeout.
  assign timeout_hit = editing_q & tick_1s & (to_cnt_q == TO_LAST) & ~any_press;

  // Next-state logic for the FSM and the edit registers; mode beats inc.
  always_comb begin
    state_d  = state_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    case (state_q)
      ST_RUN: begin
        if (press_mode) begin
          state_d  = ST_SET_H;
          edit_h_d = cap_h;
          edit_m_d = cap_m;
        end
      end
      ST_SET_H: begin
        if (press_mode) begin
          state_d = ST_SET_M;
        end else if (press_inc) begin
          edit_h_d = (edit_h_q >= 5'd23) ? 5'd0 : edit_h_q + 5'd1;
        end else if (timeout_hit) begin
          state_d = ST_RUN;
        end
      end
      ST_SET_M: begin
        if (press_mode) begin
          state_d = ST_LOAD;
        end else if (press_inc) begin
          edit_m_d = (edit_m_q >= 6'd59) ? 6'd0 : edit_m_q + 6'd1;
        end else if (timeout_hit) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        // Buttons are ignored here; only the tick releases the load.
        if (tick_1s) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign entering_edit = ((state_d == ST_SET_H) || (state_d == ST_SET_M)) &&
                         (state_d != state_q);

  // Timeout and blink counters plus the previous-level button registers.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    mode_prev_d = btn_mode;
    inc_prev_d  = btn_inc;

    if (!editing_q || any_press || entering_edit || timeout_hit) begin
      to_cnt_d = '0;
    end else if (tick_1s) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (entering_edit) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // State register; previous-button flops reset high so a held button is not a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      edit_h_q    <= '0;
      edit_m_q    <= '0;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      edit_h_q    <= edit_h_d;
      edit_m_q    <= edit_m_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
    end
  end

  // Split the binary edit values back into decimal digits.
  logic [4:0] h_base;
  logic [5:0] m_base;
  always_comb begin
    H_in1  = 2'd0;
    h_base = 5'd0;
    if (edit_h_q >= 5'd20) begin
      H_in1  = 2'd2;
      h_base = 5'd20;
    end else if (edit_h_q >= 5'd10) begin
      H_in1  = 2'd1;
      h_base = 5'd10;
    end

    M_in1  = 4'd0;
    m_base = 6'd0;
    if (edit_m_q >= 6'd60) begin
      M_in1  = 4'd6;
      m_base = 6'd60;
    end else if (edit_m_q >= 6'd50) begin
      M_in1  = 4'd5;
      m_base = 6'd50;
    end else if (edit_m_q >= 6'd40) begin
      M_in1  = 4'd4;
      m_base = 6'd40;
    end else if (edit_m_q >= 6'd30) begin
      M_in1  = 4'd3;
      m_base = 6'd30;
    end else if (edit_m_q >= 6'd20) begin
      M_in1  = 4'd2;
      m_base = 6'd20;
    end else if (edit_m_q >= 6'd10) begin
      M_in1  = 4'd1;
      m_base = 6'd10;
    end
  end

  assign H_in0 = 4'(edit_h_q - h_base);
  assign M_in0 = 4'(edit_m_q - m_base);

  assign LD_time  = (state_q == ST_LOAD);
  assign editando = editing_q;
  assign pisca_h  = (state_q == ST_SET_H) & blink_q;
  assign pisca_m  = (state_q == ST_SET_M) & blink_q;

endmodule

// File: tb/tb_ajuste_relogio.sv
// Self-checking bench for ajuste_relogio: a vector table for the basic
// flows, hand sequences for multi-cycle corners, and a randomized run
// compared against a behavioural model of the time-setting rules.
module tb_ajuste_relogio;

  localparam int BLINK = 5;
  localparam int TOUT  = 30;

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc, tick_1s;
  logic [1:0] cur_H1;
  logic [3:0] cur_H0, cur_M1, cur_M0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, editando, pisca_h, pisca_m;

  int errors = 0;
  int checks = 0;

  ajuste_relogio #(.BLINK_CICLOS(BLINK), .TIMEOUT_S(TOUT)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .tick_1s(tick_1s), .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1),
    .cur_M0(cur_M0), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1),
    .M_in0(M_in0), .LD_time(LD_time), .editando(editando),
    .pisca_h(pisca_h), .pisca_m(pisca_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    rst_n, m, i, t;
    int    cur_h, cur_m;
    bit    ld, ed, ph, pm;
    int    h, mm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] expv(bit ld, bit ed, bit ph, bit pm, int h, int m);
    logic [1:0] h1;
    logic [3:0] h0, m1, m0;
    h1 = 2'(h / 10);
    h0 = 4'(h % 10);
    m1 = 4'(m / 10);
    m0 = 4'(m % 10);
    return {ld, ed, ph, pm, h1, h0, m1, m0};
  endfunction

  function automatic logic [17:0] actv();
    return {LD_time, editando, pisca_h, pisca_m, H_in1, H_in0, M_in1, M_in0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cur(input int h, input int m);
    cur_H1 = 2'(h / 10);
    cur_H0 = 4'(h % 10);
    cur_M1 = 4'(m / 10);
    cur_M0 = 4'(m % 10);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input bit r, input bit bm, input bit bi, input bit t);
    reset    = r;
    btn_mode = bm;
    btn_inc  = bi;
    tick_1s  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input bit r, input bit bm, input bit bi, input bit t,
                     input int ch, input int cm, input bit ld, input bit ed,
                     input bit ph, input bit pm, input int h, input int m);
    vec_t v;
    v.name = n; v.rst_n = r; v.m = bm; v.i = bi; v.t = t;
    v.cur_h = ch; v.cur_m = cm; v.ld = ld; v.ed = ed; v.ph = ph; v.pm = pm;
    v.h = h; v.mm = m;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 running, 1 editing hours, 2 editing minutes, 3 loading
  int md_phase, md_h, md_m, md_since, md_ticks;
  bit md_prev_m, md_prev_i;

  task automatic model_step(input bit r, input bit bm, input bit bi, input bit t,
                            input int ch, input int cm);
    bit pm, pi;
    if (!r) begin
      md_phase = 0; md_h = 0; md_m = 0; md_since = 0; md_ticks = 0;
      md_prev_m = 1'b1; md_prev_i = 1'b1;
      return;
    end
    pm = bm && !md_prev_m;
    pi = bi && !md_prev_i;
    md_prev_m = bm;
    md_prev_i = bi;
    md_since++;
    case (md_phase)
      0: if (pm) begin
        md_phase = 1; md_h = ch; md_m = cm; md_since = 0; md_ticks = 0;
      end
      1, 2: begin
        if (pm) begin
          md_phase = (md_phase == 1) ? 2 : 3;
          md_since = 0; md_ticks = 0;
        end else if (pi) begin
          if (md_phase == 1) md_h = (md_h + 1) % 24;
          else md_m = (md_m + 1) % 60;
          md_ticks = 0;
        end else if (t) begin
          md_ticks++;
          if (md_ticks == TOUT) md_phase = 0;
        end
      end
      default: if (t) md_phase = 0;
    endcase
  endtask

  function automatic logic [17:0] model_out();
    bit blink;
    blink = ((md_since / BLINK) % 2) == 0;
    return expv(md_phase == 3, md_phase == 1 || md_phase == 2,
                md_phase == 1 && blink, md_phase == 2 && blink, md_h, md_m);
  endfunction

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; tick_1s = 1'b0;
    set_cur(0, 0);

    // ---- vector table: enter edit at 13:45 and blink; full 23:59 flow ----
    add("rst",        0,0,0,0, 13,45, 0,0,0,0, 0,0);
    add("idle",       1,0,0,0, 13,45, 0,0,0,0, 0,0);
    add("enter_seth", 1,1,0,0, 13,45, 0,1,1,0, 13,45);
    for (int k = 0; k < 4; k++) add("blink_on", 1,0,0,0, 13,45, 0,1,1,0, 13,45);
    for (int k = 0; k < 5; k++) add("blink_off", 1,0,0,0, 13,45, 0,1,0,0, 13,45);
    add("blink_on2",  1,0,0,0, 13,45, 0,1,1,0, 13,45);
    add("rst2",       0,0,0,0, 23,59, 0,0,0,0, 0,0);
    add("idle2",      1,0,0,0, 23,59, 0,0,0,0, 0,0);
    add("seth_2359",  1,1,0,0, 23,59, 0,1,1,0, 23,59);
    add("seth_hold",  1,0,0,0, 23,59, 0,1,1,0, 23,59);
    add("h_wrap",     1,0,1,0, 23,59, 0,1,1,0, 0,59);
    add("h_idle",     1,0,0,0, 23,59, 0,1,1,0, 0,59);
    add("enter_setm", 1,1,0,0, 23,59, 0,1,0,1, 0,59);
    add("setm_idle",  1,0,0,0, 23,59, 0,1,0,1, 0,59);
    add("m_wrap",     1,0,1,0, 23,59, 0,1,0,1, 0,0);
    add("m_idle",     1,0,0,0, 23,59, 0,1,0,1, 0,0);
    add("enter_load", 1,1,0,0, 23,59, 1,0,0,0, 0,0);
    add("load_hold",  1,0,0,0, 23,59, 1,0,0,0, 0,0);
    add("load_ign_i", 1,0,1,0, 23,59, 1,0,0,0, 0,0);
    add("load_idle",  1,0,0,0, 23,59, 1,0,0,0, 0,0);
    add("load_ign_m", 1,1,0,0, 23,59, 1,0,0,0, 0,0);
    add("load_exit",  1,0,0,1, 23,59, 0,0,0,0, 0,0);
    add("run_after",  1,0,0,0, 23,59, 0,0,0,0, 0,0);

    foreach (vecs[n]) begin
      set_cur(vecs[n].cur_h, vecs[n].cur_m);
      cyc(vecs[n].rst_n, vecs[n].m, vecs[n].i, vecs[n].t);
      chk(vecs[n].name, 32'(actv()),
          32'(expv(vecs[n].ld, vecs[n].ed, vecs[n].ph, vecs[n].pm, vecs[n].h, vecs[n].mm)));
      $display("vec %0d %s out=%h", n, vecs[n].name, actv());
    end

    // ---- mode and inc in the same cycle: mode wins ----
    set_cur(8, 30);
    cyc(0,0,0,0); cyc(1,0,0,0); cyc(1,1,0,0); cyc(1,0,0,0);
    cyc(1,1,1,0);
    chk("mode_inc_same", 32'(actv()), 32'(expv(0,1,0,1, 8,30)));
    cyc(1,0,0,0);
    cyc(1,0,1,0);
    chk("setm_inc", 32'(actv()), 32'(expv(0,1,0,1, 8,31)));
    $display("seq same_cycle out=%h", actv());

    // ---- idle timeout from SET_M: 30 ticks, no load ----
    cyc(1,0,0,0);
    for (int k = 1; k <= TOUT; k++) begin
      cyc(1,0,0,1);
      if (k < TOUT) chk("timeout_wait", {30'd0, LD_time, editando}, 32'd1);
      cyc(1,0,0,0);
      if (k < TOUT) chk("timeout_gap", {31'd0, LD_time}, 32'd0);
    end
    chk("timeout_run", 32'(actv()), 32'(expv(0,0,0,0, 8,31)));
    $display("seq timeout out=%h", actv());

    // ---- reset during LOAD with btn_mode held through release ----
    set_cur(10, 20);
    cyc(1,1,0,0); cyc(1,0,0,0); cyc(1,1,0,0); cyc(1,0,0,0); cyc(1,1,0,0);
    chk("load_1020", 32'(actv()), 32'(expv(1,0,0,0, 10,20)));
    cyc(0,1,0,0);
    chk("rst_in_load", 32'(actv()), 32'(expv(0,0,0,0, 0,0)));
    for (int k = 0; k < 5; k++) begin
      cyc(1,1,0,0);
      chk("held_mode", 32'(actv()), 32'(expv(0,0,0,0, 0,0)));
    end
    cyc(1,0,0,0);
    cyc(1,1,0,0);
    chk("repress", 32'(actv()), 32'(expv(0,1,1,0, 10,20)));
    $display("seq reset_load out=%h", actv());

    // ---- inc held 20 cycles gives one increment ----
    set_cur(5, 0);
    cyc(0,0,0,0); cyc(1,0,0,0); cyc(1,1,0,0); cyc(1,0,0,0);
    cyc(1,0,1,0);
    chk("inc_first", 32'(actv()), 32'(expv(0,1,1,0, 6,0)));
    for (int k = 1; k < 20; k++) cyc(1,0,1,0);
    chk("inc_held", {18'd0, H_in1, H_in0, M_in1, M_in0}, {18'd0, 14'(expv(0,0,0,0, 6,0))});
    chk("inc_held_ed", {31'd0, editando}, 32'd1);
    $display("seq inc_held out=%h", actv());

    // ---- randomized run against the model ----
    begin
      bit bm, bi, t, r;
      int ch, cm, tog;
      bm = 1'b0; bi = 1'b0; ch = 0; cm = 0;
      set_cur(0, 0);
      cyc(0,0,0,0);
      model_step(0,0,0,0, 0,0);
      chk("rand_rst", 32'(actv()), 32'(model_out()));
      for (int seg = 0; seg < 3; seg++) begin
        tog = (seg == 0) ? 20 : (seg == 1) ? 100 : 300;
        for (int n = 0; n < 1500; n++) begin
          if ($urandom_range(tog - 1) == 0) bm = ~bm;
          if ($urandom_range(tog - 1) == 0) bi = ~bi;
          t = ($urandom_range(2) == 0);
          r = ($urandom_range(399) != 0);
          if ($urandom_range(15) == 0) begin
            ch = $urandom_range(23);
            cm = $urandom_range(59);
          end
          set_cur(ch, cm);
          model_step(r, bm, bi, t, ch, cm);
          cyc(r, bm, bi, t);
          chk("rand", 32'(actv()), 32'(model_out()));
        end
        $display("random segment %0d done out=%h", seg, actv());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ajuste_relogio.md
AJUSTE_RELOGIO -- requirements
Module: ajuste_relogio

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BLINK_CICLOS, 5, clk cycles per blink half-period.
- TIMEOUT_S, 30, tick_1s pulses without a button press before edit aborts.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_mode  in  1  mode button, level, already synchronous to clk.
- btn_inc  in  1  increment button, level, already synchronous to clk.
- tick_1s  in  1  one-cycle pulse per second from the clock divider.
- cur_H1  in  2  current hour tens digit.
- cur_H0  in  4  current hour units digit.
- cur_M1  in  4  current minute tens digit.
- cur_M0  in  4  current minute units digit.
- H_in1  out  2  edited hour tens digit.
- H_in0  out  4  edited hour units digit.
- M_in1  out  4  edited minute tens digit.
- M_in0  out  4  edited minute units digit.
- LD_time  out  1  load request to the clock.
- editando  out  1  high in SET_H or SET_M.
- pisca_h  out  1  hour-display blink enable.
- pisca_m  out  1  minute-display blink enable.

REQ-003 Reset SHALL be synchronous and active-low: with reset=0 at a clk rising edge, every register SHALL take its reset value; reset SHALL have no asynchronous effect.

Function
REQ-004 Press detection SHALL register the previous level of each button; press = level AND NOT previous, asserted for one cycle.
REQ-005 FSM states SHALL be RUN, SET_H, SET_M and LOAD. Each state transition SHALL take effect on the clk edge after the triggering press.
REQ-006 In RUN, a mode press SHALL go to SET_H and capture edit_h = cur_H1*10+cur_H0 (5 bits) and edit_m = cur_M1*10+cur_M0 (6 bits).
REQ-007 In SET_H, an inc press SHALL set edit_h to edit_h+1, wrapping 23->0; a mode press SHALL go to SET_M.
REQ-008 In SET_M, an inc press SHALL set edit_m to edit_m+1, wrapping 59->0; a mode press SHALL go to LOAD.
REQ-009 In LOAD, LD_time SHALL be 1 for the whole state. LOAD SHALL be left for RUN on the first cycle in which tick_1s=1; that cycle is included, so LD_time is high across at least one tick_1s.
REQ-010 LD_time SHALL be 0 in every state other than LOAD.
REQ-011 Button presses in LOAD SHALL be ignored.
REQ-012 When mode and inc presses occur in the same cycle, mode SHALL win and inc SHALL be ignored.
REQ-013 Timeout counter:
- counts tick_1s pulses while in SET_H or SET_M;
- clears on any press and on entry to SET_H;
- on reaching TIMEOUT_S, the FSM SHALL return to RUN without LOAD, and edit values SHALL be left unchanged.
REQ-014 Edit-digit outputs SHALL be combinational splits of edit_h and edit_m:
- H_in1 = 2 if edit_h>=20, 1 if >=10, else 0; H_in0 = edit_h - 10*H_in1;
- M_in1 = floor(edit_m/10); M_in0 = edit_m - 10*M_in1.
REQ-015 edit_h and edit_m SHALL hold their values in RUN and LOAD.
REQ-016 Blink timer:
- counts clk cycles;
- toggles a blink bit every BLINK_CICLOS cycles;
- clears, with blink bit set to 1, on entry to SET_H or SET_M.
REQ-017 pisca_h SHALL equal the blink bit in SET_H and be 0 otherwise; pisca_m SHALL equal the blink bit in SET_M and be 0 otherwise.
REQ-018 editando SHALL be 1 exactly in SET_H and SET_M.

Reset
REQ-019 Reset values:
- state RUN;
- edit_h = 0, edit_m = 0, so all H_in*/M_in* outputs = 0;
- LD_time = 0, editando = 0, pisca_h = 0, pisca_m = 0;
- timeout and blink counters = 0;
- both previous-button registers = 1, so a button held through reset release produces no press.
REQ-020 Reset asserted in any state, including LOAD, SHALL give reset values on the next edge; LD_time SHALL drop that edge.

Verification
REQ-021 cur=13:45; press mode -> editando=1, state SET_H, H_in=1/3, M_in=4/5, pisca_h toggles every 5 cycles, pisca_m=0.
REQ-022 cur=23:59; mode, inc -> H_in=0/0; mode, inc -> M_in=0/0; mode -> LD_time=1 until first tick_1s, then 0; outputs stay 00:00.
REQ-023 In SET_H, mode and inc pressed in the same cycle -> state SET_M and edit_h unchanged.
REQ-024 In SET_M, 30 tick_1s with no press -> state RUN, LD_time never asserted, editando=0.
REQ-025 Reset=0 during LOAD -> next edge: LD_time=0, all outputs 0, state RUN; btn_mode held high through reset release -> no transition until released and re-pressed.
REQ-026 btn_inc held high for 20 cycles in SET_H from edit_h=5 -> edit_h=6 (a single increment).
